mmio_bus_master: RTL and testbench

Bus initiator that turns load/store requests from the rv32im core into single-cycle WRSTB/RDSTB transactions on the peripheral bus. Memory-mapped responders such as the GPIO block sit on the other end of that bus. The block handles address translation from byte to word, lane selection and sign/zero extension for loads, and read-modify-write for sub-word stores. It reports misaligned accesses without issuing any bus cycle.

---
 rtl/mmio_bus_master.sv | 154 +++++++++++++++
 tb/tb_mmio_bus_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_master.sv
// mmio_bus_master: turns core load/store requests into single-cycle
// WRSTB/RDSTB transactions on the peripheral bus. Handles byte->word
// address mapping, load lane select and extension, read-modify-write for
// sub-word stores, and rejects misaligned/illegal-size requests without
// touching the bus.
//
// Handshake: a request is taken on a rising ACLK edge where
// req_valid && req_ready; req_ready is high only while idle. resp_valid is a
// single-cycle pulse with no backpressure, and resp_err/resp_rdata are valid
// only alongside it.
module mmio_bus_master #(
  parameter int RD_LATENCY = 1
) (
  input  logic        ACLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] ADDR,
  output logic [31:0] DATA_O,
  input  logic [31:0] DATA_I,
  output logic        WRSTB,
  output logic        RDSTB,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_STB, S_RD_STB, S_RD_WAIT, S_MERGE, S_RESP, S_ERR_RESP
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(RD_LATENCY - 1);

  state_t      state, state_nxt;
  logic        accept;
  logic        req_err;
  logic        we_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic        uns_q;
  logic [15:0] wdata_q;
  logic [31:0] word_q;
  logic [1:0]  wcnt;
  logic [31:0] merged;
  logic [31:0] load_ext;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign dbg_state = state;
  assign accept    = req_valid && req_ready && (state == S_IDLE);

  // Classify the incoming request: illegal size or misaligned half/word.
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                            state_nxt = S_ERR_RESP;
          else if (req_we && req_size == 2'b10)   state_nxt = S_WR_STB;
          else                                    state_nxt = S_RD_STB;
        end
      end
      S_WR_STB:  state_nxt = S_RESP;
      S_RD_STB:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (wcnt == WAIT_LAST) state_nxt = we_q ? S_MERGE : S_RESP;
      S_MERGE:   state_nxt = S_WR_STB;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Lane merge for sub-word stores and lane extract/extend for loads.
  always_comb begin
    merged   = word_q;
    byte_sel = DATA_I[{lane_q, 3'b000} +: 8];
    half_sel = DATA_I[{lane_q[1], 4'b0000} +: 16];
    if (size_q == 2'b00) merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else                 merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_ext = DATA_I;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs follow the state being entered; datapath captures.
  always_ff @(posedge ACLK or posedge RESET) begin
    if (RESET) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'b0;
      WRSTB      <= 1'b0;
      RDSTB      <= 1'b0;
      ADDR       <= 32'b0;
      DATA_O     <= 32'b0;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= 16'b0;
      word_q     <= 32'b0;
      wcnt       <= 2'b00;
    end else begin
      req_ready  <= (state_nxt == S_IDLE);
      WRSTB      <= (state_nxt == S_WR_STB);
      RDSTB      <= (state_nxt == S_RD_STB);
      resp_valid <= (state_nxt == S_RESP) || (state_nxt == S_ERR_RESP);
      resp_err   <= (state_nxt == S_ERR_RESP);
      // Only a load reaches RESP straight from RD_WAIT, using DATA_I this cycle.
      resp_rdata <= (state == S_RD_WAIT && state_nxt == S_RESP) ? load_ext : 32'b0;
      if (accept) begin
        we_q    <= req_we;
        size_q  <= req_size;
        lane_q  <= req_addr[1:0];
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata[15:0];
        // Errors never strobe, so ADDR is left untouched for them.
        if (!req_err) ADDR <= {req_addr[31:28], 2'b00, req_addr[27:2]};
      end
      if (state_nxt == S_WR_STB)
        DATA_O <= (state == S_IDLE) ? req_wdata : merged;
      if (state == S_RD_STB)
        wcnt <= 2'b00;
      else if (state == S_RD_WAIT)
        wcnt <= wcnt + 2'd1;
      if (state == S_RD_WAIT && wcnt == WAIT_LAST)
        word_q <= DATA_I;
    end
  end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: two instances (RD_LATENCY 1 and 3) on one
// clock, each with a simple memory responder. A behavioural reference
// model (word-level memory, shift/mask arithmetic) predicts every response.
module tb_mmio_bus_master;

  logic        ACLK = 1'b0;
  logic        RESET;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic        resp_valid   [2];
  logic [31:0] resp_rdata   [2];
  logic        resp_err     [2];
  logic [31:0] ADDR         [2];
  logic [31:0] DATA_O       [2];
  logic        WRSTB        [2];
  logic        RDSTB        [2];
  logic [2:0]  dbg_state    [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory, keyed by {instance, bus word address}.
  logic [31:0] ref_mem [logic [32:0]];

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] init_word(input logic [3:0] i);
    if (i == 4'd1) return 32'h0001_2345;
    if (i == 4'd2) return 32'h1234_80FF;
    return 32'h9E37_79B9 * ({28'b0, i} + 32'd7);
  endfunction

  function automatic logic claimed(input logic [31:0] bus);
    return bus[31:4] == 28'h8000_000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] data_i;
    int          k;
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      if (claimed(a))    return init_word(a[3:0]);
      return 32'hxxxx_xxxx;
    endfunction

    mmio_bus_master #(.RD_LATENCY(L)) dut (
      .ACLK(ACLK), .RESET(RESET),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_size(req_size[g]),
      .req_unsigned(req_unsigned[g]), .resp_valid(resp_valid[g]),
      .resp_rdata(resp_rdata[g]), .resp_err(resp_err[g]), .ADDR(ADDR[g]),
      .DATA_O(DATA_O[g]), .DATA_I(data_i), .WRSTB(WRSTB[g]), .RDSTB(RDSTB[g]),
      .dbg_state(dbg_state[g])
    );

    // Responder: commits writes, presents read data only in cycle RDSTB+L.
    always @(posedge ACLK or posedge RESET) begin
      int kn;
      if (RESET) begin
        k      <= 0;
        data_i <= 32'hDEAD_BEEF;
      end else begin
        if (WRSTB[g]) mem[ADDR[g]] = DATA_O[g];
        kn = RDSTB[g] ? 1 : ((k > 0 && k < L) ? k + 1 : 0);
        k      <= kn;
        data_i <= (kn == L) ? bus_rd(ADDR[g]) : 32'hDEAD_BEEF;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input int u, input logic [31:0] bus);
    logic [32:0] key = {u[0], bus};
    if (ref_mem.exists(key)) return ref_mem[key];
    if (claimed(bus))        return init_word(bus[3:0]);
    return 32'hxxxx_xxxx;
  endfunction

  // One full transaction on instance u, checked against the reference model.
  task automatic run_txn(input int u, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic uns);
    int          lat = (u == 0) ? 1 : 3;
    logic        err;
    logic [31:0] bus, old, mask, v, exp_rdata, exp_dout;
    int          exp_rd, exp_wr, exp_resp, sh;
    logic        dout_care;
    int          rd_c, wr_c, rd_n, wr_n, resp_c;
    logic        both, addr_bad, got_err;
    logic [31:0] got_rdata, got_dout;

    err = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    bus = {a[31:28], 2'b00, a[27:2]};
    old = ref_rd(u, bus);
    sh  = 8 * int'(a[1:0]);
    exp_rd = 0; exp_wr = 0; exp_rdata = 32'h0; exp_dout = 32'h0; dout_care = 1'b0;
    if (err) begin
      exp_resp = 1;
    end else if (we && sz == 2'b10) begin
      exp_wr = 1; exp_resp = 2; exp_dout = wd; dout_care = 1'b1;
      ref_mem[{u[0], bus}] = wd;
    end else if (!we) begin
      exp_rd = 1; exp_resp = 2 + lat;
      mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      v = (old >> sh) & mask;
      if (!uns && sz == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && sz == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
      exp_rdata = v;
    end else begin
      exp_rd = 1; exp_wr = 3 + lat; exp_resp = 4 + lat;
      mask = ((sz == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      exp_dout  = (old & ~mask) | ((wd << sh) & mask);
      dout_care = claimed(bus);
      ref_mem[{u[0], bus}] = exp_dout;
    end

    @(negedge ACLK);
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = a;
    req_wdata[u] = wd; req_size[u] = sz; req_unsigned[u] = uns;
    chk("req_ready_before_accept", 32'(req_ready[u]), 32'd1);
    @(posedge ACLK);
    #1 req_valid[u] = 1'b0;

    rd_c = 0; wr_c = 0; rd_n = 0; wr_n = 0; resp_c = 0;
    both = 1'b0; addr_bad = 1'b0; got_err = 1'b0;
    got_rdata = 32'h0; got_dout = 32'h0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge ACLK);
      if (RDSTB[u] && WRSTB[u]) both = 1'b1;
      if (RDSTB[u]) begin
        rd_n++; if (rd_c == 0) rd_c = c;
        if (ADDR[u] !== bus) addr_bad = 1'b1;
      end
      if (WRSTB[u]) begin
        wr_n++; if (wr_c == 0) wr_c = c;
        got_dout = DATA_O[u];
        if (ADDR[u] !== bus) addr_bad = 1'b1;
      end
      if (resp_valid[u]) begin
        resp_c = c; got_err = resp_err[u]; got_rdata = resp_rdata[u];
        if (!err && ADDR[u] !== bus) addr_bad = 1'b1;
        break;
      end
    end
    chk("resp_cycle", resp_c, exp_resp);
    chk("resp_err", 32'(got_err), 32'(err));
    chk("resp_rdata", got_rdata, exp_rdata);
    chk("rdstb_cycle", rd_c, exp_rd);
    chk("rdstb_count", rd_n, (exp_rd != 0) ? 1 : 0);
    chk("wrstb_cycle", wr_c, exp_wr);
    chk("wrstb_count", wr_n, (exp_wr != 0) ? 1 : 0);
    chk("addr_stable", 32'(addr_bad), 32'd0);
    chk("strobe_overlap", 32'(both), 32'd0);
    if (dout_care) chk("data_o", got_dout, exp_dout);
  endtask

  task automatic chk_reset_outputs(input int u);
    chk("rst_req_ready", 32'(req_ready[u]), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid[u]), 32'd0);
    chk("rst_resp_err", 32'(resp_err[u]), 32'd0);
    chk("rst_wrstb", 32'(WRSTB[u]), 32'd0);
    chk("rst_rdstb", 32'(RDSTB[u]), 32'd0);
    chk("rst_addr", ADDR[u], 32'd0);
    chk("rst_data_o", DATA_O[u], 32'd0);
    chk("rst_resp_rdata", resp_rdata[u], 32'd0);
  endtask

  // Reset asserted while instance u waits for read data; no response may follow.
  task automatic reset_mid_op(input int u);
    logic seen;
    @(negedge ACLK);
    req_valid[u] = 1'b1; req_we[u] = 1'b0; req_addr[u] = 32'h8000_0004;
    req_size[u] = 2'b10; req_unsigned[u] = 1'b0;
    @(posedge ACLK);
    #1 req_valid[u] = 1'b0;
    @(posedge ACLK);
    #2 RESET = 1'b1;
    #1 chk_reset_outputs(u);
    @(negedge ACLK);
    RESET = 1'b0;
    @(posedge ACLK);
    #1 chk("ready_after_release", 32'(req_ready[u]), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge ACLK);
      if (resp_valid[u] || RDSTB[u] || WRSTB[u]) seen = 1'b1;
    end
    chk("no_activity_after_abort", 32'(seen), 32'd0);
    run_txn(u, 1'b0, 32'h8000_0004, 32'h0, 2'b10, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    for (int u = 0; u < 2; u++) begin
      req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = 32'h0;
      req_wdata[u] = 32'h0; req_size[u] = 2'b00; req_unsigned[u] = 1'b0;
    end
    #2;
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    @(negedge ACLK);
    RESET = 1'b0;
    @(posedge ACLK);
    #1 chk("ready_first_cycle_0", 32'(req_ready[0]), 32'd1);
    chk("ready_first_cycle_1", 32'(req_ready[1]), 32'd1);

    // Directed cases
    run_txn(0, 1'b1, 32'h8000_0000, 32'h0000_01FF, 2'b10, 1'b0);
    run_txn(0, 1'b0, 32'h8000_0004, 32'h0,         2'b10, 1'b0);
    run_txn(0, 1'b0, 32'h8000_0009, 32'h0,         2'b00, 1'b0);
    run_txn(0, 1'b0, 32'h8000_0009, 32'h0,         2'b00, 1'b1);
    run_txn(0, 1'b1, 32'h8000_0008, 32'h1122_3344, 2'b10, 1'b0);
    run_txn(0, 1'b1, 32'h8000_000A, 32'h0000_00AB, 2'b00, 1'b0);
    run_txn(0, 1'b0, 32'h8000_0008, 32'h0,         2'b10, 1'b0);
    run_txn(0, 1'b0, 32'h8000_0002, 32'h0,         2'b10, 1'b0);
    run_txn(0, 1'b1, 32'h8000_0001, 32'h0000_BEEF, 2'b01, 1'b0);
    run_txn(0, 1'b0, 32'h8000_0000, 32'h0,         2'b11, 1'b0);
    run_txn(1, 1'b0, 32'h8000_0004, 32'h0,         2'b10, 1'b0);
    run_txn(1, 1'b1, 32'h8000_000E, 32'h0000_CAFE, 2'b01, 1'b0);
    run_txn(1, 1'b0, 32'h8000_000E, 32'h0,         2'b01, 1'b0);
    run_txn(0, 1'b1, 32'h9000_0001, 32'h0000_0055, 2'b00, 1'b0);

    reset_mid_op(0);
    reset_mid_op(1);

    // Randomized traffic over the claimed window on both instances
    for (int i = 0; i < 80; i++) begin
      int          u   = int'($urandom_range(0, 1));
      logic [1:0]  sz  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      logic [31:0] a   = 32'h8000_0000 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
      run_txn(u, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
